// File: rtl/audio_i2s_adc_rx.sv
// I2S receiver for the WM8731 ADC path. Oversamples the codec-mastered
// BCLK/ADCLRC/ADCDAT pins in clk_clk, deserialises left/right words and queues
// complete stereo pairs in a show-ahead FIFO with a valid/ready output.
module audio_i2s_adc_rx #(
    parameter int DATA_W      = 24,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                             clk_clk,
    input  logic                             reset_reset_n,
    input  logic                             i2s_bclk,
    input  logic                             i2s_adclrc,
    input  logic                             i2s_adcdat,
    input  logic                             enable,
    output logic [DATA_W-1:0]                sample_left,
    output logic [DATA_W-1:0]                sample_right,
    output logic                             sample_valid,
    input  logic                             sample_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
    output logic                             overflow,
    output logic                             short_err,
    input  logic                             err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, SYNC_WAIT, DELAY, SHIFT, HOLD} state_t;

    state_t                  state, next_state;
    logic [SYNC_STAGES-1:0]  bclk_sync, lrc_sync, dat_sync;
    logic                    bclk_s, lrc_s, dat_s;
    logic                    bclk_prev, lrc_prev;
    logic                    bit_tick, lrc_edge;
    logic                    channel, left_ok;
    logic [CNT_W-1:0]        bit_cnt;
    logic                    shift_en, cnt_load, chan_load, word_done, short_set;
    logic [DATA_W-1:0]       shift_reg, left_hold, word_next;
    logic [DATA_W-1:0]       mem_left  [FIFO_DEPTH];
    logic [DATA_W-1:0]       mem_right [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic                    push, pop, full, push_ok, ovf_set;

    assign bclk_s    = bclk_sync[SYNC_STAGES-1];
    assign lrc_s     = lrc_sync[SYNC_STAGES-1];
    assign dat_s     = dat_sync[SYNC_STAGES-1];
    assign bit_tick  = bclk_s & ~bclk_prev;
    assign lrc_edge  = bit_tick & (lrc_s != lrc_prev);
    assign word_next = {shift_reg[DATA_W-2:0], dat_s};

    // Synchronise the asynchronous codec pins and remember last BCLK/LRC levels
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            bclk_sync <= '0;
            lrc_sync  <= '0;
            dat_sync  <= '0;
            bclk_prev <= 1'b0;
            lrc_prev  <= 1'b0;
        end else begin
            bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0], i2s_adclrc};
            dat_sync  <= {dat_sync[SYNC_STAGES-2:0], i2s_adcdat};
            bclk_prev <= bclk_s;
            if (bit_tick) lrc_prev <= lrc_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) state <= IDLE;
        else                state <= next_state;
    end

    // Next-state and per-tick datapath controls; the edge tick itself carries the I2S delay bit
    always_comb begin
        next_state = state;
        shift_en   = 1'b0;
        cnt_load   = 1'b0;
        chan_load  = 1'b0;
        word_done  = 1'b0;
        short_set  = 1'b0;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: next_state = SYNC_WAIT;
                SYNC_WAIT: begin
                    if (lrc_edge && !lrc_s) begin
                        next_state = DELAY;
                        chan_load  = 1'b1;
                    end
                end
                DELAY: begin
                    if (lrc_edge) begin
                        chan_load = 1'b1;
                    end else if (bit_tick) begin
                        next_state = SHIFT;
                        shift_en   = 1'b1;
                        cnt_load   = 1'b1;
                    end
                end
                SHIFT: begin
                    if (lrc_edge) begin
                        next_state = DELAY;
                        chan_load  = 1'b1;
                        short_set  = 1'b1;
                    end else if (bit_tick) begin
                        shift_en = 1'b1;
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                            word_done  = 1'b1;
                            next_state = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (lrc_edge) begin
                        next_state = DELAY;
                        chan_load  = 1'b1;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Channel, bit counter and left-word-pending bookkeeping
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            channel <= 1'b0;
            left_ok <= 1'b0;
            bit_cnt <= '0;
        end else begin
            if (chan_load) channel <= lrc_s;
            if (cnt_load)      bit_cnt <= CNT_W'(1);
            else if (shift_en) bit_cnt <= bit_cnt + CNT_W'(1);
            if (state == IDLE || short_set) left_ok <= 1'b0;
            else if (word_done)             left_ok <= ~channel;
        end
    end

    // Serial shift register and completed left word (data path, no reset)
    always_ff @(posedge clk_clk) begin
        if (shift_en) shift_reg <= word_next;
        if (word_done && !channel) left_hold <= word_next;
    end

    assign push    = word_done & channel & left_ok;
    assign sample_valid = (fifo_level != '0);
    assign pop     = sample_valid & sample_ready;
    assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    // FIFO storage; a push on a full FIFO with a pop overwrites the slot being consumed
    always_ff @(posedge clk_clk) begin
        if (push_ok) begin
            mem_left[wr_ptr]  <= left_hold;
            mem_right[wr_ptr] <= word_next;
        end
    end

    // FIFO pointers, level and sticky error flags (a set beats a coincident clear)
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            short_err  <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            overflow  <= ovf_set   | (overflow  & ~err_clr);
            short_err <= short_set | (short_err & ~err_clr);
        end
    end

    assign sample_left  = sample_valid ? mem_left[rd_ptr]  : '0;
    assign sample_right = sample_valid ? mem_right[rd_ptr] : '0;

endmodule

// File: tb/tb_audio_i2s_adc_rx.sv
// Testbench for audio_i2s_adc_rx: drives I2S frames at BCLK = clk/16 with
// 32-bit slots and checks the FIFO output against a frame-level model.
module tb_audio_i2s_adc_rx;

    localparam int DATA_W      = 24;
    localparam int FIFO_DEPTH  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;
    localparam int SLOT        = 32;

    typedef struct {
        logic [DATA_W-1:0] l;
        logic [DATA_W-1:0] r;
    } pair_t;

    typedef struct {
        logic [DATA_W-1:0] l_in;
        logic [DATA_W-1:0] r_in;
        int                pad;
        logic [DATA_W-1:0] l_exp;
        logic [DATA_W-1:0] r_exp;
    } vec_t;

    logic              clk = 1'b0;
    logic              reset_reset_n;
    logic              i2s_bclk, i2s_adclrc, i2s_adcdat, enable;
    logic [DATA_W-1:0] sample_left, sample_right;
    logic              sample_valid, sample_ready;
    logic [2:0]        fifo_level;
    logic              overflow, short_err, err_clr;

    int    tests_run, tests_failed, model_drop;
    logic  scb_on, rand_ready, prev_lrc_one;
    pair_t exp_q[$];
    vec_t  vecs[4];

    audio_i2s_adc_rx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_clk       (clk),
        .reset_reset_n (reset_reset_n),
        .i2s_bclk      (i2s_bclk),
        .i2s_adclrc    (i2s_adclrc),
        .i2s_adcdat    (i2s_adcdat),
        .enable        (enable),
        .sample_left   (sample_left),
        .sample_right  (sample_right),
        .sample_valid  (sample_valid),
        .sample_ready  (sample_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .short_err     (short_err),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are final at this point; a handshake now means a pop at the next rising edge.
    task automatic wait_clk();
        pair_t e;
        if (scb_on && sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("FAIL scb_extra: got pair %h/%h, required no pair", sample_left, sample_right);
            end else begin
                e = exp_q.pop_front();
                check("scb_left", 64'(sample_left), 64'(e.l));
                check("scb_right", 64'(sample_right), 64'(e.r));
            end
        end
        @(negedge clk);
        if (rand_ready) sample_ready = ($urandom_range(0, 1) == 1);
    endtask

    task automatic send_bit(input logic lrc, input logic d, output int lat);
        lat = 0;
        i2s_bclk   = 1'b0;
        i2s_adclrc = lrc;
        i2s_adcdat = d;
        repeat (HALF) wait_clk();
        i2s_bclk = 1'b1;
        for (int c = 1; c <= HALF; c++) begin
            wait_clk();
            if (lat == 0 && sample_valid) lat = c;
        end
        if (lrc && reset_reset_n) prev_lrc_one = 1'b1;
    endtask

    // Slot bit 0 is the I2S delay bit, bits 1..DATA_W the word MSB first, the rest padding.
    task automatic send_slot_n(input logic lrc, input logic [DATA_W-1:0] w, input int pad, input int nbits);
        int   lat;
        logic d;
        for (int i = 0; i < nbits; i++) begin
            if (i >= 1 && i <= DATA_W) d = w[DATA_W-i];
            else if (pad == 0)         d = 1'b0;
            else if (pad == 1)         d = 1'b1;
            else                       d = 1'($urandom_range(0, 1));
            send_bit(lrc, d, lat);
        end
    endtask

    // Model: a full frame that follows a right slot while enabled yields one pair.
    task automatic send_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r, input int pad);
        pair_t p;
        if (scb_on && enable && prev_lrc_one) begin
            p.l = l;
            p.r = r;
            if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(p);
            else                           model_drop++;
        end
        send_slot_n(1'b0, l, pad, SLOT);
        send_slot_n(1'b1, r, pad, SLOT);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        sample_ready = 1'b1;
        while (sample_valid && n < 64) begin
            wait_clk();
            n++;
        end
        sample_ready = 1'b0;
        wait_clk();
        check({name, "_level"}, 64'(fifo_level), 64'(0));
        if (scb_on) check({name, "_pending"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int                lat;
        logic              d;
        logic [DATA_W-1:0] l5[5], r5[5];
        pair_t             p5;

        tests_run = 0; tests_failed = 0; model_drop = 0;
        reset_reset_n = 1'b0;
        i2s_bclk = 1'b0; i2s_adclrc = 1'b0; i2s_adcdat = 1'b0;
        enable = 1'b0; sample_ready = 1'b0; err_clr = 1'b0;
        scb_on = 1'b0; rand_ready = 1'b0; prev_lrc_one = 1'b0;

        vecs[0] = '{24'h000000, 24'hFFFFFF, 1, 24'h000000, 24'hFFFFFF};
        vecs[1] = '{24'hFFFFFF, 24'h000000, 0, 24'hFFFFFF, 24'h000000};
        vecs[2] = '{24'h800000, 24'h000001, 2, 24'h800000, 24'h000001};
        vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 1, 24'hA5A5A5, 24'h5A5A5A};

        repeat (4) wait_clk();
        check("rst_valid", 64'(sample_valid), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_left", 64'(sample_left), 64'(0));
        check("rst_right", 64'(sample_right), 64'(0));
        check("rst_overflow", 64'(overflow), 64'(0));
        check("rst_short_err", 64'(short_err), 64'(0));

        reset_reset_n = 1'b1;
        enable = 1'b1;
        wait_clk();
        send_slot_n(1'b1, '0, 0, SLOT);

        // Test 1: single pair, pin-to-valid latency, one-cycle pop
        send_slot_n(1'b0, 24'h123456, 0, SLOT);
        for (int i = 0; i < SLOT; i++) begin
            d = (i >= 1 && i <= DATA_W) ? logic'((24'hABCDEF >> (DATA_W - i)) & 1) : 1'b0;
            send_bit(1'b1, d, lat);
            if (i == DATA_W) begin
                check("t1_latency", 64'(lat), 64'(SYNC_STAGES + 1));
                check("t1_level", 64'(fifo_level), 64'(1));
                check("t1_left", 64'(sample_left), 64'(24'h123456));
                check("t1_right", 64'(sample_right), 64'(24'hABCDEF));
                sample_ready = 1'b1;
                wait_clk();
                sample_ready = 1'b0;
                wait_clk();
                check("t1_valid_after_pop", 64'(sample_valid), 64'(0));
                check("t1_level_after_pop", 64'(fifo_level), 64'(0));
            end
        end

        // Table-driven word patterns with differing delay/padding bits
        for (int k = 0; k < 4; k++) begin
            send_frame(vecs[k].l_in, vecs[k].r_in, vecs[k].pad);
            check($sformatf("tbl%0d_level", k), 64'(fifo_level), 64'(1));
            check($sformatf("tbl%0d_left", k), 64'(sample_left), 64'(vecs[k].l_exp));
            check($sformatf("tbl%0d_right", k), 64'(sample_right), 64'(vecs[k].r_exp));
            drain($sformatf("tbl%0d_drain", k));
        end

        // Test 2: enable in the middle of a right slot
        enable = 1'b0;
        send_slot_n(1'b0, 24'($urandom), 2, SLOT);
        send_slot_n(1'b1, 24'($urandom), 2, 16);
        enable = 1'b1;
        send_slot_n(1'b1, 24'($urandom), 2, 16);
        scb_on = 1'b1;
        sample_ready = 1'b1;
        send_frame(24'h0A0A0A, 24'h0B0B0B, 2);
        send_frame(24'h1C1C1C, 24'h1D1D1D, 2);
        drain("t2");
        check("t2_short_err", 64'(short_err), 64'(0));

        // Test 3: overflow with consumer stalled, then clear
        sample_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_frame(24'($urandom), 24'($urandom), 2);
        check("t3_level", 64'(fifo_level), 64'(FIFO_DEPTH));
        check("t3_overflow", 64'(overflow), 64'(model_drop > 0));
        drain("t3");
        err_clr = 1'b1;
        wait_clk();
        err_clr = 1'b0;
        wait_clk();
        check("t3_overflow_clr", 64'(overflow), 64'(0));

        // Test 4: LRC toggles after 10 left data bits
        sample_ready = 1'b1;
        send_slot_n(1'b0, 24'($urandom), 2, 11);
        send_slot_n(1'b1, 24'($urandom), 2, SLOT);
        check("t4_short_err", 64'(short_err), 64'(1));
        check("t4_no_push", 64'(fifo_level), 64'(0));
        send_frame(24'h2468AC, 24'h13579B, 2);
        drain("t4");
        err_clr = 1'b1;
        wait_clk();
        err_clr = 1'b0;
        wait_clk();
        check("t4_short_clr", 64'(short_err), 64'(0));

        // Test 5: pop and push on the same clock while full
        sample_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            l5[k] = 24'($urandom);
            r5[k] = 24'($urandom);
        end
        for (int k = 0; k < 4; k++) send_frame(l5[k], r5[k], 2);
        send_slot_n(1'b0, l5[4], 2, SLOT);
        for (int i = 0; i < DATA_W; i++) send_bit(1'b1, (i == 0) ? 1'b0 : r5[4][DATA_W-i], lat);
        i2s_bclk   = 1'b0;
        i2s_adclrc = 1'b1;
        i2s_adcdat = r5[4][0];
        repeat (HALF) wait_clk();
        check("t5_full_before", 64'(fifo_level), 64'(FIFO_DEPTH));
        i2s_bclk = 1'b1;
        wait_clk();
        wait_clk();
        p5.l = l5[4];
        p5.r = r5[4];
        exp_q.push_back(p5);
        sample_ready = 1'b1;
        wait_clk();
        sample_ready = 1'b0;
        check("t5_level", 64'(fifo_level), 64'(FIFO_DEPTH));
        check("t5_overflow", 64'(overflow), 64'(0));
        check("t5_head_left", 64'(sample_left), 64'(l5[1]));
        check("t5_head_right", 64'(sample_right), 64'(r5[1]));
        repeat (HALF - 3) wait_clk();
        for (int i = DATA_W + 1; i < SLOT; i++) send_bit(1'b1, 1'b0, lat);
        drain("t5");

        // Test 6: reset in the middle of a left word
        send_frame(24'($urandom), 24'($urandom), 2);
        check("t6_valid_before", 64'(sample_valid), 64'(1));
        send_slot_n(1'b0, 24'($urandom), 2, 12);
        reset_reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(sample_valid), 64'(0));
        check("t6_rst_level", 64'(fifo_level), 64'(0));
        check("t6_rst_left", 64'(sample_left), 64'(0));
        check("t6_rst_right", 64'(sample_right), 64'(0));
        check("t6_rst_overflow", 64'(overflow), 64'(0));
        check("t6_rst_short_err", 64'(short_err), 64'(0));
        exp_q.delete();
        prev_lrc_one = 1'b0;
        repeat (3) wait_clk();
        reset_reset_n = 1'b1;
        send_slot_n(1'b0, 24'($urandom), 2, 20);
        send_slot_n(1'b1, 24'($urandom), 2, SLOT);
        check("t6_no_partial", 64'(fifo_level), 64'(0));
        sample_ready = 1'b1;
        send_frame(24'h3C3C3C, 24'hC3C3C3, 2);
        drain("t6");

        // Randomised frames with a randomly stalling consumer
        rand_ready = 1'b1;
        for (int k = 0; k < 6; k++) send_frame(24'($urandom), 24'($urandom), 2);
        rand_ready = 1'b0;
        drain("rand");
        check("rand_overflow", 64'(overflow), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
